// File: rtl/mips8_muldiv.sv
// Iterative unsigned multiply/divide unit: one shift-add (MULTU) or restoring-subtract (DIVU)
// step per clock, results parked in HI/LO until the next completion.
module mips8_muldiv #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  // acc: partial remainder / high product half; mq: multiplier or dividend -> quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   trial_diff;
  logic             qbit;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mq_nx;
  logic             last;
  logic             accept;

  // One datapath step, selected by the latched opcode.
  always_comb begin
    add_sum    = mq_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
    // WIDTH+1-bit trial keeps the shifted-out remainder MSB so no false borrow occurs.
    trial      = {acc_q, mq_q[WIDTH-1]};
    trial_diff = trial - {1'b0, b_q};
    qbit       = (trial >= {1'b0, b_q});
    if (op_q) begin
      acc_nx = qbit ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];
      mq_nx  = {mq_q[WIDTH-2:0], qbit};
    end else begin
      acc_nx = add_sum[WIDTH:1];
      mq_nx  = {add_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept = start_i && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StRun: begin
        acc_d = acc_nx;
        mq_d  = mq_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = StDone;
          hi_d    = acc_nx;
          lo_d    = mq_nx;
          dbz_d   = op_q && (b_q == '0);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      state_d = StRun;
      cnt_d   = '0;
      op_d    = op_i;
      b_d     = b_i;
      acc_d   = '0;
      mq_d    = a_i;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule
